// File: rtl/stream_fifo.sv
// Stream FIFO with valid/ready handshakes, first-word-fall-through output, occupancy flags.
// Optional high-water mark register enabled by the STREAM_FIFO_PEAK_EN macro.
module stream_fifo #(
  parameter int DW        = 32,
  parameter int N         = 32,
  parameter int AF_THRESH = N - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data,
  output logic [$clog2(N):0]    count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [$clog2(N):0]    peak
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [N];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  assign s_ready      = (count_q < CW'(N));
  assign m_valid      = (count_q != '0);
  assign m_data       = mem[rd_ptr];
  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count_q + 1'b1;
        2'b01:   count_nxt = count_q - 1'b1;
        default: count_nxt = count_q;
      endcase
    end
  end

  // Pointers are AW bits wide, so N being a power of two makes the wrap implicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
    end
  end

  // Storage has no reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= s_data;
  end

`ifdef STREAM_FIFO_PEAK_EN
  logic [CW-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
    end else if (count_nxt > peak_q) begin
      peak_q <= count_nxt;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter DW, default 32: data width in bits, >=1.
REQ-002 Parameter N, default 32: depth in entries, power of two, >=2.
REQ-003 Parameter AF_THRESH, default N-2: almost_full threshold, 1..N.
REQ-004 Parameter AE_THRESH, default 2: almost_empty threshold, 0..N-1.
REQ-005 clk  in  1: clock; all state changes on the rising edge.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 flush  in  1: synchronous clear of contents.
REQ-008 s_valid  in  1: upstream word valid.
REQ-009 s_ready  out  1: FIFO accepts a word this cycle.
REQ-010 s_data  in  DW: upstream word.
REQ-011 m_valid  out  1: head word valid.
REQ-012 m_ready  in  1: downstream consumes head this cycle.
REQ-013 m_data  out  DW: head word, first-word-fall-through.
REQ-014 count  out  $clog2(N)+1: current occupancy, 0..N.
REQ-015 almost_full  out  1: count >= AF_THRESH.
REQ-016 almost_empty  out  1: count <= AE_THRESH.
REQ-017 peak  out  $clog2(N)+1: high-water mark of count (see Configuration).

Function
REQ-018 Push occurs on an edge where s_valid && s_ready; the word is stored at wr_ptr and wr_ptr increments modulo N.
REQ-019 Pop occurs on an edge where m_valid && m_ready; rd_ptr increments modulo N.
REQ-020 s_ready SHALL equal (count < N), combinationally from registered state, independent of m_ready (no push-through when full).
REQ-021 m_valid SHALL equal (count != 0); m_data SHALL equal mem[rd_ptr] combinationally whenever m_valid=1; m_data is don't-care when m_valid=0.
REQ-022 Latency: a word pushed at edge k is presented with m_valid=1 in the cycle after edge k; no bypass when empty.
REQ-023 count: +1 on push only, -1 on pop only, unchanged on push and pop together or neither.
REQ-024 Simultaneous push and pop at 0<count<N SHALL both complete; count unchanged; ordering preserved.
REQ-025 s_valid while full and m_ready while empty SHALL be ignored: no state change, no error.
REQ-026 Pointers wrap from N-1 to 0 without loss or reordering.
REQ-027 flush=1 at an edge SHALL zero wr_ptr, rd_ptr, count; push and pop that edge are discarded; flush does not clear peak.
REQ-028 almost_full and almost_empty are combinational from count.

Reset
REQ-029 rst=1 at an edge SHALL zero wr_ptr, rd_ptr, count, peak; rst has priority over flush, push, pop.
REQ-030 Outputs after reset: s_ready=1, m_valid=0, count=0, almost_full=0, almost_empty=1, peak=0.
REQ-031 Memory contents are not reset; reset mid-stream drops all stored words.

Configuration
REQ-032 Macro STREAM_FIFO_PEAK_EN defined: peak register updates each edge to max(peak, next count), cleared only by rst.
REQ-033 Macro undefined: no peak register is built and peak SHALL be tied to 0.

Verification (bench params DW=8, N=4, AF_THRESH=3, AE_THRESH=1)
REQ-034 After rst, push 0x11,0x22,0x33,0x44 with m_ready=0 -> count 1,2,3,4; almost_full=1 at count 3; s_ready=0 at count 4; 5th push 0x55 ignored.
REQ-035 From full, m_ready=1 for 4 cycles -> m_data 0x11,0x22,0x33,0x44 in order; m_valid=0 and count=0 after; extra pop ignored.
REQ-036 count=2, s_valid=m_ready=1 for 10 cycles with incrementing data -> count stays 2, output order equals input order across pointer wrap.
REQ-037 count=3, flush=1 with s_valid=m_ready=1 -> next cycle count=0, m_valid=0, s_ready=1; peak (macro defined) remains 3.
REQ-038 Empty, push 0xA5 at edge k -> m_valid=1, m_data=0xA5 in cycle k+1, not earlier.
REQ-039 rst asserted at count=3 concurrently with push and flush -> count=0, peak=0, almost_empty=1; with macro undefined peak=0 throughout.
